// File: rtl/data_mem_responder.sv
// Word-addressed data memory that answers single CPU load/store requests
// after a programmable wait, with byte-enabled stores and fault reporting.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        ready_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        accept;
    logic        enter_resp;

    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic [31:0] rdata_q;
    logic        err_q;

    logic        acc_we;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_be;
    logic        acc_fault;
    logic [IDX_W-1:0] acc_idx;
    logic        wr_en;

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_i) begin
                    accept = 1'b1;
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            be_q    <= be_i;
        end
    end

    // With zero latency the access happens on the accepting edge, so the
    // request fields come straight from the inputs instead of the latches.
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
            acc_be    = be_i;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_be    = be_q;
        end
    end

    assign acc_fault = (acc_addr[1:0] != 2'b00) ||
                       ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
    assign acc_idx   = acc_addr[IDX_W+1:2];
    assign wr_en     = enter_resp && acc_we && !acc_fault && !rst_i;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (acc_be[k]) begin
                    mem[acc_idx][8*k +: 8] <= acc_wdata[8*k +: 8];
                end
            end
        end
    end

    // Response registers self-clear on every edge that does not enter RESP.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            err_q   <= enter_resp && acc_fault;
            rdata_q <= (enter_resp && !acc_we && !acc_fault) ? mem[acc_idx] : 32'h0;
        end
    end

    assign ready_o = (state_q == RESP);
    assign busy_o  = (state_q != IDLE);
    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule
